// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader: FIFO geometry, default
// read latency / skid depth and the delivered-word counter width.
package fifo_stream_reader_pkg;
  localparam int FIFO_DW        = 60;
  localparam int FIFO_AW        = 8;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_SKID_DEPTH = 2;
  localparam int CNT_W          = 32;
endpackage

// File: rtl/fifo_stream_skid.sv
// DEPTH x DW register skid buffer: push at tail, pop at head, occupancy count,
// valid/data presented straight from registered state.
module fifo_stream_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int DW              = FIFO_DW,
  parameter int DEPTH           = DEF_SKID_DEPTH,
  localparam int OCC_W          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  output logic             pop,
  output logic [OCC_W-1:0] occ
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_valid = (occ != '0);
  assign m_data  = m_valid ? mem[head] : '0;
  assign pop     = m_valid && m_ready;

  // NOTE: buffer entries carry no reset; occ qualifies every read, so only
  // the pointers and count need one.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr)
    !(push && !pop && (occ == OCC_W'(DEPTH))))
    else $error("fifo_stream_skid overflow");
`endif
endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: credit-gated FIFO reads, RD_LAT in-flight pipe and a
// skid buffer feeding a valid/ready stream. FIFO_STREAM_READER_CNT_EN enables rd_count.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DW         = FIFO_DW,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_dout,
  output logic             fifo_re,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count
);
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  logic [RD_LAT-1:0] pipe;
  logic [OCC_W-1:0]  occ;
  logic              pop;
  logic              land;
  int                inflight;

  assign inflight = $countones(pipe);
  assign land     = pipe[RD_LAT-1];
  assign busy     = (occ != '0) || (pipe != '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fifo_re = 1'b0;
    // Reserve a slot for every word already buffered or in flight.
    if (!rst && !clr && !fifo_empty)
      fifo_re = (int'(occ) - int'(pop) + inflight + 1) <= SKID_DEPTH;
  end

  // NOTE: non-blocking assignments let each stage shift from its pre-edge value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pipe <= '0;
    end else begin
      pipe[0] <= fifo_re;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  fifo_stream_skid #(
    .DW    (DW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (land),
    .push_data (fifo_dout),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .pop       (pop),
    .occ       (occ)
  );

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Survives clr on purpose; only rst zeroes the delivered-word count.
  always_ff @(posedge clk) begin
    if (rst)      cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: two reader instances (RD_LAT=1/SKID=2 and RD_LAT=2/SKID=3), each fed
// by a behavioural 256-entry FIFO; delivered words are compared with a queue model.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  localparam int DW = FIFO_DW;
`ifdef FIFO_STREAM_READER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [1:0]              wr_en;
  logic [1:0][DW-1:0]      wr_data;
  logic [1:0]              m_ready;
  logic [1:0]              fifo_empty;
  logic [1:0]              fifo_re;
  logic [1:0]              m_valid;
  logic [1:0]              busy;
  logic [1:0][DW-1:0]      fifo_dout;
  logic [1:0][DW-1:0]      m_data;
  logic [1:0][CNT_W-1:0]   rd_count;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 2;
    localparam int DEP = (g == 0) ? 2 : 3;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] dq  [LAT];
    logic [7:0]    wp;
    logic [7:0]    rp;
    int            cnt = 0;

    assign fifo_empty[g] = (cnt == 0);
    assign fifo_dout[g]  = dq[LAT-1];

    // Registered-RAM FIFO: word at rp shows on dout LAT cycles after re.
    always @(posedge clk) begin
      if (rst || clr) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= 0;
      end else begin
        if (wr_en[g]) begin
          mem[wp] <= wr_data[g];
          wp      <= wp + 8'd1;
        end
        if (fifo_re[g]) begin
          dq[0] <= mem[rp];
          rp    <= rp + 8'd1;
        end
        cnt <= cnt + int'(wr_en[g]) - int'(fifo_re[g]);
      end
      for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
    end

    fifo_stream_reader #(
      .DW         (DW),
      .RD_LAT     (LAT),
      .SKID_DEPTH (DEP)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .fifo_empty (fifo_empty[g]),
      .fifo_dout  (fifo_dout[g]),
      .fifo_re    (fifo_re[g]),
      .m_valid    (m_valid[g]),
      .m_ready    (m_ready[g]),
      .m_data     (m_data[g]),
      .busy       (busy[g]),
      .rd_count   (rd_count[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int issued, delivered, cyc;
  int first_re, first_valid, first_xfer, last_xfer;
  int v_re_empty, v_stable, v_credit, v_busy;
  int xfer_total [2];
  logic prev_stall;
  logic [DW-1:0] prev_data;
  logic s_valid, s_re, s_busy;
  logic [DW-1:0] got [$];
  logic [DW-1:0] exp_q [$];

  function automatic int dep_of(input int s);
    return (s == 0) ? 2 : 3;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom, $urandom});
  endfunction

  function automatic int seq_errs();
    int e = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] exp_count(input int s);
    return CNT_EN ? CNT_W'(xfer_total[s]) : '0;
  endfunction

  // One clock of stimulus on instance s plus bookkeeping of what was observed.
  task automatic tick(input int s, input logic rdy, input logic wr,
                      input logic [DW-1:0] wd, input logic c);
    @(negedge clk);
    m_ready[s] = rdy;
    wr_en[s]   = wr;
    wr_data[s] = wd;
    clr        = c;
    #1;
    s_valid = m_valid[s];
    s_re    = fifo_re[s];
    s_busy  = busy[s];
    if (fifo_re[s] && fifo_empty[s]) v_re_empty++;
    if (prev_stall && (!m_valid[s] || m_data[s] !== prev_data)) v_stable++;
    if (busy[s] !== (issued != delivered)) v_busy++;
    if (fifo_re[s]) begin
      issued++;
      if (first_re < 0) first_re = cyc;
    end
    if (m_valid[s] && first_valid < 0) first_valid = cyc;
    if (m_valid[s] && rdy) begin
      got.push_back(m_data[s]);
      delivered++;
      xfer_total[s]++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
    end
    if (issued - delivered > dep_of(s)) v_credit++;
    prev_stall = m_valid[s] && !rdy;
    prev_data  = m_data[s];
    if (c) begin
      issued     = 0;
      delivered  = 0;
      prev_stall = 1'b0;
    end
    cyc++;
  endtask

  task automatic clear_stats();
    v_re_empty = 0; v_stable = 0; v_credit = 0; v_busy = 0;
    first_re = -1; first_valid = -1; first_xfer = -1; last_xfer = -1;
    cyc = 0; prev_stall = 1'b0;
    got.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; clr = 1'b0; m_ready = '0; wr_en = '0;
    @(negedge clk);
    rst = 1'b0;
    issued = 0; delivered = 0; prev_stall = 1'b0;
    xfer_total[0] = 0; xfer_total[1] = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_stats();
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({fifo_re[s], m_valid[s], busy[s]} !== 3'b000) begin
        n_bad++; $display("FAIL reset_flags[%0d]: got %b expected 000", s, {fifo_re[s], m_valid[s], busy[s]});
      end
      n_cmp++;
      if (m_data[s] !== '0) begin
        n_bad++; $display("FAIL reset_data[%0d]: got %h expected 0", s, m_data[s]);
      end
      n_cmp++;
      if (rd_count[s] !== '0) begin
        n_bad++; $display("FAIL reset_count[%0d]: got %0d expected 0", s, rd_count[s]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] w;
      w = rand_word();
      exp_q.push_back(w);
      tick(0, 1'b0, 1'b1, w, 1'b0);
    end
    for (int i = 0; i < 40 && got.size() < 3; i++) tick(0, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (got.size() !== 3 || seq_errs() !== 0) begin
      n_bad++; $display("FAIL reset_prestream: got %0d words (%0d wrong) expected 3", got.size(), seq_errs());
    end
    apply_reset();
    n_cmp++;
    if ({fifo_re[0], m_valid[0], busy[0]} !== 3'b000) begin
      n_bad++; $display("FAIL midreset_flags: got %b expected 000", {fifo_re[0], m_valid[0], busy[0]});
    end
    n_cmp++;
    if (m_data[0] !== '0) begin
      n_bad++; $display("FAIL midreset_data: got %h expected 0", m_data[0]);
    end
    n_cmp++;
    if (rd_count[0] !== '0) begin
      n_bad++; $display("FAIL midreset_count: got %0d expected 0", rd_count[0]);
    end
  endtask

  task automatic test_full_rate();
    clear_stats();
    for (int i = 0; i < 600 && got.size() < 200; i++) begin
      logic [DW-1:0] w;
      w = DW'(i);
      if (i < 200) exp_q.push_back(w);
      tick(0, 1'b1, i < 200, w, 1'b0);
    end
    n_cmp++;
    if (got.size() !== 200 || seq_errs() !== 0) begin
      n_bad++; $display("FAIL full_rate_order: got %0d words (%0d wrong) expected 200", got.size(), seq_errs());
    end
    n_cmp++;
    if (first_valid - first_re !== 2) begin
      n_bad++; $display("FAIL full_rate_latency: got %0d expected 2", first_valid - first_re);
    end
    n_cmp++;
    if (last_xfer - first_xfer !== 199) begin
      n_bad++; $display("FAIL full_rate_gapless: got span %0d expected 199", last_xfer - first_xfer);
    end
    n_cmp++;
    if (rd_count[0] !== exp_count(0)) begin
      n_bad++; $display("FAIL full_rate_count: got %0d expected %0d", rd_count[0], exp_count(0));
    end
    n_cmp++;
    if (v_busy !== 0) begin
      n_bad++; $display("FAIL full_rate_busy: got %0d bad cycles expected 0", v_busy);
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    for (int i = 0; i < 400 && got.size() < 20; i++) begin
      logic [DW-1:0] w;
      logic r;
      w = DW'(i);
      r = (i >= 20) && (((i - 20) % 4 == 0) || ((i - 20) % 4 == 3));
      if (i < 20) exp_q.push_back(w);
      tick(0, r, i < 20, w, 1'b0);
    end
    n_cmp++;
    if (got.size() !== 20 || seq_errs() !== 0) begin
      n_bad++; $display("FAIL bp_order: got %0d words (%0d wrong) expected 20", got.size(), seq_errs());
    end
    n_cmp++;
    if (v_stable !== 0) begin
      n_bad++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", v_stable);
    end
    n_cmp++;
    if (v_credit !== 0) begin
      n_bad++; $display("FAIL bp_credit: got %0d over-credit cycles expected 0", v_credit);
    end
  endtask

  task automatic test_empty_boundary();
    logic [DW-1:0] w0, w1;
    int gap_valid, gap_busy;
    clear_stats();
    w0 = rand_word();
    w1 = rand_word();
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    tick(0, 1'b1, 1'b1, w0, 1'b0);
    for (int i = 0; i < 20 && got.size() < 1; i++) tick(0, 1'b1, 1'b0, '0, 1'b0);
    gap_valid = 0;
    gap_busy  = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 1'b1, 1'b0, '0, 1'b0);
      gap_valid += int'(s_valid);
      gap_busy  += int'(s_busy);
    end
    tick(0, 1'b1, 1'b1, w1, 1'b0);
    for (int i = 0; i < 20 && got.size() < 2; i++) tick(0, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (got.size() !== 2 || seq_errs() !== 0) begin
      n_bad++; $display("FAIL empty_order: got %0d words (%0d wrong) expected 2", got.size(), seq_errs());
    end
    n_cmp++;
    if (gap_valid !== 0 || gap_busy !== 0) begin
      n_bad++; $display("FAIL empty_gap: got valid=%0d busy=%0d cycles expected 0/0", gap_valid, gap_busy);
    end
    n_cmp++;
    if (v_re_empty !== 0) begin
      n_bad++; $display("FAIL empty_re: got %0d reads while empty expected 0", v_re_empty);
    end
  endtask

  task automatic test_clr_inflight();
    logic [DW-1:0] w;
    logic pre_re, pre_valid;
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      w = rand_word();
      if (i == 0) exp_q.push_back(w);
      tick(0, 1'b0, 1'b1, w, 1'b0);
    end
    repeat (2) tick(0, 1'b0, 1'b0, '0, 1'b0);
    tick(0, 1'b1, 1'b0, '0, 1'b0);
    pre_re    = s_re;
    pre_valid = s_valid;
    tick(0, 1'b0, 1'b0, '0, 1'b1);
    tick(0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++;
    if ({pre_re, pre_valid} !== 2'b11) begin
      n_bad++; $display("FAIL clr_setup: got re,valid=%b expected 11", {pre_re, pre_valid});
    end
    n_cmp++;
    if ({s_valid, s_busy} !== 2'b00) begin
      n_bad++; $display("FAIL clr_flush: got valid,busy=%b expected 00", {s_valid, s_busy});
    end
    n_cmp++;
    if (rd_count[0] !== exp_count(0)) begin
      n_bad++; $display("FAIL clr_count: got %0d expected %0d", rd_count[0], exp_count(0));
    end
    for (int i = 0; i < 2; i++) begin
      w = rand_word();
      exp_q.push_back(w);
      tick(0, 1'b1, 1'b1, w, 1'b0);
    end
    for (int i = 0; i < 20 && got.size() < 3; i++) tick(0, 1'b1, 1'b0, '0, 1'b0);
    repeat (3) tick(0, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (got.size() !== 3 || seq_errs() !== 0) begin
      n_bad++; $display("FAIL clr_no_stale: got %0d words (%0d wrong) expected 3", got.size(), seq_errs());
    end
  endtask

  task automatic test_wrap_full();
    clear_stats();
    for (int i = 0; i < 3000 && got.size() < 256; i++) begin
      logic [DW-1:0] w;
      logic r;
      w = rand_word();
      r = 1'($urandom_range(0, 1));
      if (i < 256) exp_q.push_back(w);
      tick(1, r, i < 256, w, 1'b0);
    end
    n_cmp++;
    if (got.size() !== 256 || seq_errs() !== 0) begin
      n_bad++; $display("FAIL wrap_order: got %0d words (%0d wrong) expected 256", got.size(), seq_errs());
    end
    n_cmp++;
    if (first_valid - first_re !== 3) begin
      n_bad++; $display("FAIL wrap_latency: got %0d expected 3", first_valid - first_re);
    end
    n_cmp++;
    if (v_credit !== 0 || v_stable !== 0) begin
      n_bad++; $display("FAIL wrap_protocol: got credit=%0d stable=%0d expected 0/0", v_credit, v_stable);
    end
    n_cmp++;
    if (v_re_empty !== 0 || v_busy !== 0) begin
      n_bad++; $display("FAIL wrap_flags: got re_empty=%0d busy=%0d expected 0/0", v_re_empty, v_busy);
    end
    n_cmp++;
    if (rd_count[1] !== exp_count(1)) begin
      n_bad++; $display("FAIL wrap_count: got %0d expected %0d", rd_count[1], exp_count(1));
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; m_ready = '0; wr_en = '0; wr_data = '0;
    issued = 0; delivered = 0; cyc = 0;
    xfer_total[0] = 0; xfer_total[1] = 0;
    prev_stall = 1'b0; prev_data = '0;
    s_valid = 1'b0; s_re = 1'b0; s_busy = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset();
    test_reset();
    test_full_rate();
    test_backpressure();
    test_empty_boundary();
    test_clr_inflight();
    test_wrap_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
